teclado_escaner: RTL and testbench
==================================

# teclado_escaner

Scans a 4x4 matrix keypad, debounces presses, and emits one single-cycle event per key press. The digit event (`numero_en`, `nuevo_numero`) feeds the calculator's digit-entry logic, which shifts digits into its 16-bit operand. Operator keys raise a separate strobe for the operation-selection logic. Sits between the board keypad pins and the calculator control FSMs.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each column is driven before advancing; must be ≥ 4.
- `DEBOUNCE_CYC`, default 50000: consecutive stable cycles required to accept a press, and separately to accept a release; must be ≥ 2.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `filas`  in  4  keypad rows; active-low, pulled up; asynchronous to `clk`.
- `columnas`  out  4  column drive; active-low, exactly one bit low at any time.
- `nuevo_numero`  out  4  code of the last accepted key; held until the next accepted key.
- `numero_en`  out  1  one-cycle strobe when the accepted key is a digit (code 0–9).
- `operacion_en`  out  1  one-cycle strobe when the accepted key is a non-digit (code A–F).
- `tecla_activa`  out  1  high from the EMIT cycle until the release is accepted.

## Operation
- `filas` passes through a 2-flop synchronizer (reset value 4'b1111). All logic uses only the synchronized value `fs`.
- Key map, row r / column c, codes in hex:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E(*) 0 F(#) D
- FSM states:
  - **SCAN**:
    - Column index `col` cycles 0→1→2→3→0; one step every `SCAN_DIV` cycles.
    - `columnas = ~(1<<col)`.
    - `fs` is sampled only on the last cycle of each dwell. If `fs != 4'b1111`, latch `col` and `row` = lowest-index low bit, clear the counter, and go to DEBOUNCE.
  - **DEBOUNCE**:
    - `col` is frozen.
    - Each cycle `fs[row]==0` increments the counter.
    - Any cycle `fs[row]==1` returns to SCAN; `col` advances to the next column.
    - The counter reaching `DEBOUNCE_CYC` goes to EMIT.
  - **EMIT** (1 cycle):
    - Load `nuevo_numero`.
    - Pulse `numero_en` if code ≤ 9, else `operacion_en`.
    - Set `tecla_activa`.
    - Go to HOLD.
  - **HOLD**:
    - `col` is frozen.
    - Counter counts consecutive cycles with `fs == 4'b1111`; any low row clears it.
    - Reaching `DEBOUNCE_CYC` clears `tecla_activa` and returns to SCAN, with `col` advanced to the next column and the dwell counter cleared.
- Multiple simultaneous keys in the scanned column: lowest row wins.
- Keys pressed during HOLD are ignored. Every key must be released before any new event is produced (no auto-repeat, no rollover).
- Reset value of every output:
  - `columnas` = 4'b1110
  - `nuevo_numero` = 0
  - `numero_en` = 0
  - `operacion_en` = 0
  - `tecla_activa` = 0
  - state = SCAN, all counters = 0
- Reset asserted mid-operation aborts immediately. No strobe is emitted for a key whose debounce was interrupted.

## Timing
- Strobes are registered, exactly 1 cycle wide, and mutually exclusive. At most one strobe per physical press.
- Press latency:
  - 2 cycles for synchronization.
  - Wait until the end of the current dwell (≤ `SCAN_DIV` cycles).
  - `DEBOUNCE_CYC` cycles of debounce.
  - The strobe rises on the cycle after the counter reaches `DEBOUNCE_CYC`.
- `nuevo_numero` is valid in the strobe cycle and stays stable afterwards; consumers may sample it with or after the strobe.
- Minimum spacing between two strobes: 2·`DEBOUNCE_CYC` + 2 cycles.
- Counter widths: `$clog2(SCAN_DIV)` and `$clog2(DEBOUNCE_CYC+1)`. Counters saturate and never wrap.

## Structure
- Shared package `calc_pkg` holds:
  - the key-code constants: `TECLA_A`..`TECLA_D`, `TECLA_AST` = 4'hE, `TECLA_NUM` = 4'hF
  - the state encoding
  - the 16-entry row/column→code lookup function
- One natural sub-module: `sincronizador` (parameterized-width 2-flop synchronizer with reset value input), used for `filas`.

## Test plan
Benches use `SCAN_DIV`=4, `DEBOUNCE_CYC`=8.
1. **Reset**: assert `reset` mid-scan → `columnas`=4'b1110, all strobes 0, `nuevo_numero`=0 on the same edge.
2. **Digit press**: hold key r1/c1 low for 40 cycles, then release → exactly one `numero_en` pulse with `nuevo_numero`=4'h5; `operacion_en` never asserts; `tecla_activa` falls 8 cycles after release is synchronized.
3. **Bounce**: row low for 5 cycles, high for 2, then low for 20 → no strobe during the bounce; exactly one strobe 8 stable cycles after the final fall.
4. **Operator key**: key r3/c2 (#) → `operacion_en` pulse with `nuevo_numero`=4'hF; `numero_en`=0 throughout.
5. **Two keys**: r0/c0 and r2/c0 pressed together → single strobe with code 4'h1. Then press r3/c1 while still in HOLD → ignored; after full release, a new press of r3/c1 → `numero_en` with 4'h0.
6. **Reset during debounce**: reset at debounce count 5 → no strobe; after release of reset, scanning restarts from column 0.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator definitions: key codes, scanner state encoding and
// the row/column to key-code lookup used by the keypad scanner.
package calc_pkg;

    localparam logic [3:0] TECLA_A   = 4'hA;
    localparam logic [3:0] TECLA_B   = 4'hB;
    localparam logic [3:0] TECLA_C   = 4'hC;
    localparam logic [3:0] TECLA_D   = 4'hD;
    localparam logic [3:0] TECLA_AST = 4'hE;
    localparam logic [3:0] TECLA_NUM = 4'hF;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        EMIT     = 2'd2,
        HOLD     = 2'd3
    } estado_t;

    // Physical keypad layout: row r, column c -> key code.
    function automatic logic [3:0] tecla_codigo(input logic [1:0] fila, input logic [1:0] col);
        logic [3:0] codigo;
        case ({fila, col})
            4'd0:    codigo = 4'h1;
            4'd1:    codigo = 4'h2;
            4'd2:    codigo = 4'h3;
            4'd3:    codigo = TECLA_A;
            4'd4:    codigo = 4'h4;
            4'd5:    codigo = 4'h5;
            4'd6:    codigo = 4'h6;
            4'd7:    codigo = TECLA_B;
            4'd8:    codigo = 4'h7;
            4'd9:    codigo = 4'h8;
            4'd10:   codigo = 4'h9;
            4'd11:   codigo = TECLA_C;
            4'd12:   codigo = TECLA_AST;
            4'd13:   codigo = 4'h0;
            4'd14:   codigo = TECLA_NUM;
            default: codigo = TECLA_D;
        endcase
        return codigo;
    endfunction

    // Lowest-index active-low row; with several keys down the lowest row wins.
    function automatic logic [1:0] fila_baja(input logic [3:0] fs);
        logic [1:0] fila;
        if (!fs[0])      fila = 2'd0;
        else if (!fs[1]) fila = 2'd1;
        else if (!fs[2]) fila = 2'd2;
        else             fila = 2'd3;
        return fila;
    endfunction

endpackage

// File: rtl/teclado_escaner_if.sv
// Key event bus from the keypad scanner to the calculator control logic.
// Semantics: numero_en / operacion_en are single-cycle, mutually exclusive
// strobes with no back-pressure (the consumer must accept in that cycle);
// nuevo_numero is valid in the strobe cycle and held until the next event;
// tecla_activa is a level that stays high until the key release is accepted.
interface teclado_escaner_if;
    logic [3:0] nuevo_numero;
    logic       numero_en;
    logic       operacion_en;
    logic       tecla_activa;

    modport master (output nuevo_numero, output numero_en, output operacion_en, output tecla_activa);
    modport slave  (input  nuevo_numero, input  numero_en, input  operacion_en, input  tecla_activa);
endinterface

// File: rtl/teclado_escaner_sincronizador.sv
// Parameterized-width two-flop synchronizer with a caller-supplied reset value.
module sincronizador #(
    parameter int ANCHO = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ANCHO-1:0] valor_reset,
    input  logic [ANCHO-1:0] d,
    output logic [ANCHO-1:0] q
);
    logic [ANCHO-1:0] etapa1;

    // Two back-to-back flops to resolve metastability on the async input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            etapa1 <= valor_reset;
            q      <= valor_reset;
        end else begin
            etapa1 <= d;
            q      <= etapa1;
        end
    end
endmodule

// File: rtl/teclado_escaner.sv
// 4x4 matrix keypad scanner: column scan, press/release debounce and
// one registered single-cycle event per accepted key press.
module teclado_escaner
    import calc_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CYC = 50000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         filas,
    output logic [3:0]         columnas,
    teclado_escaner_if.master  evt,
    output estado_t            estado
);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DEB_W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [DIV_W-1:0] DIV_ULT = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_UNO = DIV_W'(1);
    localparam logic [DEB_W-1:0] DEB_ULT = DEB_W'(DEBOUNCE_CYC - 1);
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEBOUNCE_CYC);
    localparam logic [DEB_W-1:0] DEB_UNO = DEB_W'(1);

    logic [3:0]       fs;
    estado_t          estado_q, estado_sig;
    logic [1:0]       col, col_sig;
    logic [1:0]       fila, fila_sig;
    logic [DIV_W-1:0] div_cnt, div_sig;
    logic [DEB_W-1:0] deb_cnt, deb_sig;
    logic [3:0]       codigo;
    logic             numero_sig, operacion_sig, activa_sig;

    sincronizador #(.ANCHO(4)) u_sinc_filas (
        .clk         (clk),
        .reset       (reset),
        .valor_reset (4'b1111),
        .d           (filas),
        .q           (fs)
    );

    assign estado = estado_q;

    // State register together with the column index, latched row and counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q <= SCAN;
            col      <= 2'd0;
            fila     <= 2'd0;
            div_cnt  <= '0;
            deb_cnt  <= '0;
        end else begin
            estado_q <= estado_sig;
            col      <= col_sig;
            fila     <= fila_sig;
            div_cnt  <= div_sig;
            deb_cnt  <= deb_sig;
        end
    end

    // Next state: scan dwell, press debounce, single emit cycle, release debounce.
    always_comb begin
        estado_sig = estado_q;
        col_sig    = col;
        fila_sig   = fila;
        div_sig    = div_cnt;
        deb_sig    = deb_cnt;
        case (estado_q)
            SCAN: begin
                if (div_cnt == DIV_ULT) begin
                    div_sig = '0;
                    if (fs != 4'b1111) begin
                        fila_sig   = fila_baja(fs);
                        deb_sig    = '0;
                        estado_sig = DEBOUNCE;
                    end else begin
                        col_sig = col + 2'd1;
                    end
                end else begin
                    div_sig = div_cnt + DIV_UNO;
                end
            end
            DEBOUNCE: begin
                if (fs[fila]) begin
                    // Bounce: give up on this key and move on to the next column.
                    estado_sig = SCAN;
                    col_sig    = col + 2'd1;
                    div_sig    = '0;
                    deb_sig    = '0;
                end else begin
                    if (deb_cnt != DEB_MAX) deb_sig = deb_cnt + DEB_UNO;
                    if (deb_cnt == DEB_ULT) estado_sig = EMIT;
                end
            end
            EMIT: begin
                estado_sig = HOLD;
                deb_sig    = '0;
            end
            default: begin
                // HOLD: wait for DEBOUNCE_CYC consecutive cycles with no row low.
                if (fs != 4'b1111) begin
                    deb_sig = '0;
                end else if (deb_cnt == DEB_ULT) begin
                    estado_sig = SCAN;
                    col_sig    = col + 2'd1;
                    div_sig    = '0;
                    deb_sig    = '0;
                end else if (deb_cnt != DEB_MAX) begin
                    deb_sig = deb_cnt + DEB_UNO;
                end
            end
        endcase
    end

    // Output decode: column drive and next values of the registered event outputs.
    always_comb begin
        columnas      = ~(4'b0001 << col);
        codigo        = tecla_codigo(fila, col);
        numero_sig    = (estado_sig == EMIT) && (codigo <= 4'd9);
        operacion_sig = (estado_sig == EMIT) && (codigo > 4'd9);
        activa_sig    = (estado_sig == EMIT) || (estado_sig == HOLD);
    end

    // Registered event outputs so strobes are glitch-free and exactly one cycle wide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            evt.nuevo_numero <= 4'd0;
            evt.numero_en    <= 1'b0;
            evt.operacion_en <= 1'b0;
            evt.tecla_activa <= 1'b0;
        end else begin
            if (estado_sig == EMIT) evt.nuevo_numero <= codigo;
            evt.numero_en    <= numero_sig;
            evt.operacion_en <= operacion_sig;
            evt.tecla_activa <= activa_sig;
        end
    end
endmodule

// File: tb/tb_teclado_escaner.sv
// Directed bench for teclado_escaner with a behavioural 4x4 keypad model.
module tb_teclado_escaner;
    import calc_pkg::*;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CYC = 8;
    localparam int LIMITE       = 60;

    logic       clk;
    logic       reset;
    logic [3:0] filas;
    logic [3:0] columnas;
    estado_t    estado;
    logic [15:0] teclas;   // teclas[r*4+c] = key at row r, column c held down

    int checks;
    int failures;
    int n_num;
    int n_op;
    int n_ambos;
    int base_num;
    int base_op;
    bit visto;

    teclado_escaner_if evt ();

    teclado_escaner #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .filas    (filas),
        .columnas (columnas),
        .evt      (evt),
        .estado   (estado)
    );

    // Clock: 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad: a held key pulls its row low while its column is driven low.
    always_comb begin
        filas = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (teclas[r*4+c] && !columnas[c]) filas[r] = 1'b0;
    end

    // Strobe counters sampled on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (evt.numero_en)    n_num++;
            if (evt.operacion_en) n_op++;
            if (evt.numero_en && evt.operacion_en) n_ambos++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_strobe(input int limite, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limite && !ok; i++) begin
            @(negedge clk);
            if (evt.numero_en || evt.operacion_en) ok = 1'b1;
        end
    endtask

    task automatic wait_suelta(input int limite, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limite && !ok; i++) begin
            @(negedge clk);
            if (!evt.tecla_activa) ok = 1'b1;
        end
    endtask

    task automatic wait_debounce(input int limite, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limite && !ok; i++) begin
            @(negedge clk);
            if (estado == DEBOUNCE) ok = 1'b1;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        n_num    = 0;
        n_op     = 0;
        n_ambos  = 0;
        teclas   = 16'h0000;
        reset    = 1'b1;
        step(3);
        reset = 1'b0;

        // 1. Reset mid-scan: after 6 cycles the scan is on column 1.
        step(6);
        chk("scan_col1", columnas, 4'b1101);
        reset = 1'b1;
        #1;
        chk("rst_columnas", columnas, 4'b1110);
        chk("rst_numero_en", evt.numero_en, 1'b0);
        chk("rst_operacion_en", evt.operacion_en, 1'b0);
        chk("rst_nuevo", evt.nuevo_numero, 4'h0);
        chk("rst_activa", evt.tecla_activa, 1'b0);
        chk("rst_estado", estado, SCAN);
        step(2);
        reset = 1'b0;
        step(3);

        // 2. Digit press r1/c1 held 40 cycles -> one numero_en with code 5.
        base_num = n_num; base_op = n_op;
        teclas[5] = 1'b1;
        wait_strobe(LIMITE, visto);
        chk("dig_timeout", visto, 1'b1);
        chk("dig_numero_en", evt.numero_en, 1'b1);
        chk("dig_code", evt.nuevo_numero, 4'h5);
        chk("dig_activa", evt.tecla_activa, 1'b1);
        step(40);
        chk("dig_code_held", evt.nuevo_numero, 4'h5);
        chk("dig_activa_hold", evt.tecla_activa, 1'b1);
        teclas[5] = 1'b0;
        // 2 sync cycles + 8 release cycles: still high after 9, low after 10.
        step(9);
        chk("dig_activa_9", evt.tecla_activa, 1'b1);
        step(1);
        chk("dig_activa_10", evt.tecla_activa, 1'b0);
        step(20);
        chk("dig_count_num", n_num - base_num, 1);
        chk("dig_count_op", n_op - base_op, 0);

        // 3. Bounce on r2/c2: 5 low, 2 high, then low -> one strobe, code 9.
        base_num = n_num; base_op = n_op;
        teclas[10] = 1'b1;
        step(5);
        teclas[10] = 1'b0;
        step(2);
        teclas[10] = 1'b1;
        step(9);
        chk("bnc_no_early", (n_num - base_num) + (n_op - base_op), 0);
        wait_strobe(LIMITE, visto);
        chk("bnc_timeout", visto, 1'b1);
        chk("bnc_code", evt.nuevo_numero, 4'h9);
        step(5);
        teclas[10] = 1'b0;
        wait_suelta(LIMITE, visto);
        chk("bnc_release", visto, 1'b1);
        step(20);
        chk("bnc_count_num", n_num - base_num, 1);
        chk("bnc_count_op", n_op - base_op, 0);

        // 4. Operator key r3/c2 (#) -> operacion_en with code F.
        base_num = n_num; base_op = n_op;
        teclas[14] = 1'b1;
        wait_strobe(LIMITE, visto);
        chk("op_timeout", visto, 1'b1);
        chk("op_operacion_en", evt.operacion_en, 1'b1);
        chk("op_numero_en", evt.numero_en, 1'b0);
        chk("op_code", evt.nuevo_numero, TECLA_NUM);
        step(10);
        teclas[14] = 1'b0;
        wait_suelta(LIMITE, visto);
        chk("op_release", visto, 1'b1);
        step(20);
        chk("op_count_op", n_op - base_op, 1);
        chk("op_count_num", n_num - base_num, 0);

        // 5. r0/c0 + r2/c0 together -> code 1; r3/c1 during HOLD is ignored.
        base_num = n_num; base_op = n_op;
        teclas[0] = 1'b1;
        teclas[8] = 1'b1;
        wait_strobe(LIMITE, visto);
        chk("two_timeout", visto, 1'b1);
        chk("two_code", evt.nuevo_numero, 4'h1);
        step(3);
        teclas[13] = 1'b1;
        step(6);
        teclas[13] = 1'b0;
        step(3);
        teclas[0] = 1'b0;
        teclas[8] = 1'b0;
        wait_suelta(LIMITE, visto);
        chk("two_release", visto, 1'b1);
        step(25);
        chk("two_count_num", n_num - base_num, 1);
        chk("two_hold_ignored_code", evt.nuevo_numero, 4'h1);
        teclas[13] = 1'b1;
        wait_strobe(LIMITE, visto);
        chk("zero_timeout", visto, 1'b1);
        chk("zero_numero_en", evt.numero_en, 1'b1);
        chk("zero_code", evt.nuevo_numero, 4'h0);
        step(5);
        teclas[13] = 1'b0;
        wait_suelta(LIMITE, visto);
        chk("zero_release", visto, 1'b1);
        step(20);
        chk("two_total_num", n_num - base_num, 2);
        chk("two_total_op", n_op - base_op, 0);

        // 6. Reset at debounce count 5 -> no strobe, scan restarts at column 0.
        base_num = n_num; base_op = n_op;
        teclas[0] = 1'b1;
        wait_debounce(LIMITE, visto);
        chk("rd_reach_debounce", visto, 1'b1);
        step(5);
        reset = 1'b1;
        #1;
        chk("rd_estado", estado, SCAN);
        chk("rd_columnas", columnas, 4'b1110);
        chk("rd_activa", evt.tecla_activa, 1'b0);
        step(2);
        teclas[0] = 1'b0;
        step(1);
        reset = 1'b0;
        step(3);
        chk("rd_col0", columnas, 4'b1110);
        step(2);
        chk("rd_col1", columnas, 4'b1101);
        step(30);
        chk("rd_no_strobe", (n_num - base_num) + (n_op - base_op), 0);

        chk("strobes_exclusive", n_ambos, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
